// File: rtl/text_cell_sequencer.sv
// text_cell_sequencer: character-cell text datapath feeding the font ROM.
// Single-port cell buffer shared by display fetch, host writes and clear.
module text_cell_sequencer #(
   parameter int         COLS     = 16,
   parameter int         ROWS     = 4,
   parameter int         ORIGIN_X = 8,
   parameter int         ORIGIN_Y = 300,
   parameter logic [3:0] BLANK    = 4'd15,
   parameter int         AW       = 6
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pix_en,
   input  logic [9:0]    x,
   input  logic [9:0]    y,
   input  logic          valid,
   input  logic          clr,
   input  logic          wr_req,
   input  logic [AW-1:0] wr_addr,
   input  logic [3:0]    wr_data,
   output logic          wr_ack,
   output logic          busy,
   output logic [3:0]    char,
   output logic [2:0]    rownum,
   output logic          font_en,
   input  logic [7:0]    pixels,
   output logic          out_px
);

   localparam int CW    = $clog2(COLS);
   localparam int RW    = $clog2(ROWS);
   localparam int DEPTH = COLS * ROWS;
   localparam int IW    = CW + RW;

   localparam logic [9:0] X0 = 10'(ORIGIN_X);
   localparam logic [9:0] X1 = 10'(ORIGIN_X + 8 * COLS);
   localparam logic [9:0] Y0 = 10'(ORIGIN_Y);
   localparam logic [9:0] Y1 = 10'(ORIGIN_Y + 8 * ROWS);

   localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

   typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

   state_t          r_state;
   logic [IW-1:0]   r_cnt;
   logic            r_busy;
   logic            r_ack;

   logic [3:0]      r_mem [DEPTH];
   logic [3:0]      r_rd_data;

   logic            r_hit1;
   logic [2:0]      r_grow1;
   logic [2:0]      r_bit1;
   logic [2:0]      r_bit2;
   logic [3:0]      r_char;
   logic [2:0]      r_row;
   logic            r_fen;
   logic            r_px;

   logic [CW+2:0]   w_dx;
   logic [RW+2:0]   w_dy;
   logic            w_hit;
   logic [IW-1:0]   w_rd_addr;
   logic            w_disp;
   logic            w_free;
   logic            w_clr_we;
   logic            w_host_we;
   logic            w_wr_in;

   // only the low bits of the offsets are needed for cell and glyph position
   assign w_dx      = x[CW+2:0] - X0[CW+2:0];
   assign w_dy      = y[RW+2:0] - Y0[RW+2:0];
   assign w_hit     = valid & (x >= X0) & (x < X1) & (y >= Y0) & (y < Y1);
   assign w_rd_addr = {w_dy[RW+2:3], w_dx[CW+2:3]};

   assign w_disp    = pix_en & w_hit;
   assign w_free    = ~w_disp;
   assign w_clr_we  = (r_state == ST_CLEAR) & w_free;
   assign w_host_we = ~r_busy & w_free & wr_req & ~r_ack;

   generate
      if (DEPTH < (2 ** AW)) begin : g_range
         assign w_wr_in = (wr_addr < AW'(DEPTH));
      end else begin : g_full
         assign w_wr_in = 1'b1;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (w_disp) begin
         r_rd_data <= r_mem[w_rd_addr];
      end else if (w_clr_we) begin
         r_mem[r_cnt] <= BLANK;
      end else if (w_host_we && w_wr_in) begin
         r_mem[wr_addr[IW-1:0]] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hit1  <= 1'b0;
         r_grow1 <= 3'd0;
         r_bit1  <= 3'd0;
         r_bit2  <= 3'd0;
         r_char  <= BLANK;
         r_row   <= 3'd0;
         r_fen   <= 1'b0;
         r_px    <= 1'b0;
      end else if (pix_en) begin
         r_hit1  <= w_hit;
         r_grow1 <= w_dy[2:0];
         r_bit1  <= w_dx[2:0];
         r_char  <= r_hit1 ? r_rd_data : BLANK;
         r_row   <= r_grow1;
         r_fen   <= r_hit1;
         r_bit2  <= r_bit1;
         r_px    <= r_fen & pixels[3'd7 - r_bit2];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_CLEAR;
         r_cnt   <= '0;
         r_busy  <= 1'b1;
         r_ack   <= 1'b0;
      end else begin
         r_ack <= w_host_we;
         case (r_state)
            ST_IDLE: begin
               if (clr) begin
                  r_state <= ST_CLEAR;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
               end
            end
            ST_CLEAR: begin
               if (clr) begin
                  r_cnt <= '0;
               end else if (w_free) begin
                  r_cnt <= r_cnt + 1'b1;
                  if (r_cnt == LAST) begin
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign wr_ack  = r_ack;
   assign busy    = r_busy;
   assign char    = r_char;
   assign rownum  = r_row;
   assign font_en = r_fen;
   assign out_px  = r_px;

endmodule

// File: tb/tb_text_cell_sequencer.sv
// tb_text_cell_sequencer: random and directed stimulus against a
// cell-level reference model of the text datapath.
module tb_text_cell_sequencer;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, pix_en, valid, clr, wr_req;
   logic [9:0] x, y;
   logic [5:0] wr_addr;
   logic [3:0] wr_data;
   logic       wr_ack, busy, font_en, out_px;
   logic [3:0] char_o;
   logic [2:0] rownum;
   logic [7:0] pixels;

   logic       s8_en, s8_req;
   logic [9:0] s8_x, s8_y;
   logic [5:0] s8_addr;
   logic [3:0] s8_data;
   logic       ack8, busy8, fen8, px8;
   logic [3:0] char8;
   logic [2:0] row8;
   logic [7:0] pix8;

   typedef struct packed {
      logic       hit;
      logic [3:0] code;
      logic [2:0] grow;
      logic [2:0] bitx;
      logic       known;
   } ent_t;

   ent_t       s1, s2, s3;
   logic [3:0] m_mem [64];
   int         m_left;
   logic       m_ack;
   int         n_chk, n_fail, n;

   function automatic logic [7:0] font(input logic [3:0] c,
                                       input logic [2:0] r);
      return ({c, ~c} ^ {r, r, r[1:0]}) ^ 8'hA5;
   endfunction

   function automatic logic in_win(input int px, input int py,
                                   input logic v);
      return v && px >= 8 && px < 136 && py >= 300 && py < 332;
   endfunction

   assign pixels = font(char_o, rownum);
   assign pix8   = font(char8, row8);

   text_cell_sequencer u_dut (
      .clk(clk), .rst(rst), .pix_en(pix_en), .x(x), .y(y),
      .valid(valid), .clr(clr), .wr_req(wr_req), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_ack(wr_ack), .busy(busy), .char(char_o),
      .rownum(rownum), .font_en(font_en), .pixels(pixels),
      .out_px(out_px)
   );

   text_cell_sequencer #(.COLS(8)) u_dut8 (
      .clk(clk), .rst(rst), .pix_en(s8_en), .x(s8_x), .y(s8_y),
      .valid(1'b1), .clr(1'b0), .wr_req(s8_req), .wr_addr(s8_addr),
      .wr_data(s8_data), .wr_ack(ack8), .busy(busy8), .char(char8),
      .rownum(row8), .font_en(fen8), .pixels(pix8), .out_px(px8)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_init();
      s1 = '{hit: 1'b0, code: 4'd15, grow: 3'd0, bitx: 3'd0,
             known: 1'b1};
      s2 = s1;
      s3 = s1;
      m_left = 64;
      m_ack = 1'b0;
   endtask

   task automatic cycle();
      logic       hit, disp, acc;
      int         dx, dy;
      ent_t       ne;
      logic [7:0] pb;
      hit  = in_win(int'(x), int'(y), valid);
      disp = pix_en && hit;
      acc  = wr_req && m_left == 0 && !disp && !m_ack;
      dx   = (int'(x) - 8 + 1024) % 1024;
      dy   = (int'(y) - 300 + 1024) % 1024;
      ne.hit   = hit;
      ne.code  = 4'd15;
      if (hit) ne.code = m_mem[dy / 8 * 16 + dx / 8];
      ne.grow  = 3'(dy % 8);
      ne.bitx  = 3'(dx % 8);
      ne.known = !hit || m_left == 0;
      @(posedge clk);
      if (pix_en) begin
         s3 = s2;
         s2 = s1;
         s1 = ne;
      end
      if (acc) m_mem[wr_addr] = wr_data;
      m_ack = acc;
      if (clr) begin
         m_left = 64;
      end else if (m_left > 0 && !disp) begin
         m_left--;
         if (m_left == 0) foreach (m_mem[i]) m_mem[i] = 4'd15;
      end
      #1;
      chk("busy", 32'(busy), 32'(m_left > 0));
      chk("wr_ack", 32'(wr_ack), 32'(m_ack));
      chk("font_en", 32'(font_en), 32'(s2.hit));
      chk("rownum", 32'(rownum), 32'(s2.grow));
      if (s2.known) chk("char", 32'(char_o), 32'(s2.code));
      if (s3.known) begin
         pb = font(s3.code, s3.grow);
         chk("out_px", 32'(out_px),
             32'(s3.hit & pb[7 - int'(s3.bitx)]));
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      wr_req = 1'b0;
      clr = 1'b0;
      pix_en = 1'b0;
      valid = 1'b0;
      s8_req = 1'b0;
      s8_en = 1'b0;
      #2;
      chk("rst_char", 32'(char_o), 32'd15);
      chk("rst_rownum", 32'(rownum), 32'd0);
      chk("rst_font_en", 32'(font_en), 32'd0);
      chk("rst_out_px", 32'(out_px), 32'd0);
      chk("rst_wr_ack", 32'(wr_ack), 32'd0);
      chk("rst_busy", 32'(busy), 32'd1);
      model_init();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic strobe(input int px, input int py);
      pix_en = 1'b1;
      valid = 1'b1;
      x = 10'(px);
      y = 10'(py);
      cycle();
      pix_en = 1'b0;
   endtask

   task automatic flush();
      valid = 1'b0;
      pix_en = 1'b1;
      x = 10'd0;
      y = 10'd0;
      cycle();
      cycle();
      pix_en = 1'b0;
   endtask

   task automatic host_write(input logic [5:0] a, input logic [3:0] d);
      int k = 0;
      wr_req = 1'b1;
      wr_addr = a;
      wr_data = d;
      do begin
         cycle();
         k++;
      end while (!wr_ack && k < 500);
      chk("wr_done", 32'(wr_ack), 32'd1);
      wr_req = 1'b0;
   endtask

   task automatic write8(input logic [5:0] a, input logic [3:0] d,
                         input string tag);
      int k = 0;
      s8_req = 1'b1;
      s8_addr = a;
      s8_data = d;
      do begin
         cycle();
         k++;
      end while (!ack8 && k < 20);
      chk(tag, 32'(ack8), 32'd1);
      s8_req = 1'b0;
      cycle();
   endtask

   task automatic read8(input int px, input int py, input logic [3:0] e,
                        input string tag);
      s8_en = 1'b1;
      s8_x = 10'(px);
      s8_y = 10'(py);
      cycle();
      s8_x = 10'd0;
      s8_y = 10'd0;
      cycle();
      s8_en = 1'b0;
      chk(tag, 32'(char8), 32'(e));
      chk("font_en8", 32'(fen8), 32'd1);
   endtask

   task automatic rand_run(input int ncyc);
      int wait_n = 0;
      for (int i = 0; i < ncyc; i++) begin
         pix_en = $urandom_range(0, 2) != 0;
         valid = $urandom_range(0, 7) != 0;
         x = 10'($urandom_range(0, 143));
         y = 10'($urandom_range(296, 335));
         clr = $urandom_range(0, 299) == 0;
         if (wr_req && wr_ack) wr_req = 1'b0;
         if (!wr_req && $urandom_range(0, 3) == 0) begin
            wr_req = 1'b1;
            wr_addr = 6'($urandom);
            wr_data = 4'($urandom);
            wait_n = 0;
         end
         cycle();
         if (wr_req && !wr_ack) begin
            wait_n++;
            if (wait_n > 1000) begin
               chk("wr_timeout", 32'(wait_n), 32'd0);
               wr_req = 1'b0;
            end
         end
      end
      clr = 1'b0;
      pix_en = 1'b0;
      wait_n = 0;
      while (wr_req && !wr_ack && wait_n < 500) begin
         cycle();
         wait_n++;
      end
      if (wr_req && !wr_ack) chk("wr_drain", 32'(wr_ack), 32'd1);
      wr_req = 1'b0;
   endtask

   initial begin
      int bx[6] = '{7, 136, 8, 8, 135, 72};
      int by[6] = '{300, 300, 299, 332, 331, 331};
      n_chk = 0;
      n_fail = 0;
      foreach (m_mem[i]) m_mem[i] = 4'd15;
      x = 10'd0;
      y = 10'd0;
      wr_addr = 6'd0;
      wr_data = 4'd0;
      s8_x = 10'd0;
      s8_y = 10'd0;
      s8_addr = 6'd0;
      s8_data = 4'd0;
      do_reset();

      n = 0;
      while (busy && n < 200) begin
         cycle();
         n++;
      end
      chk("clr_len", 32'(n), 32'd64);

      for (int c = 0; c < 64; c++)
         strobe(8 + 8 * (c % 16) + int'($urandom_range(0, 7)),
                300 + 8 * (c / 16) + int'($urandom_range(0, 7)));
      flush();

      host_write(6'd0, 4'd10);
      for (int i = 0; i < 8; i++) strobe(8 + i, 300);
      flush();

      host_write(6'd63, 4'd6);
      for (int i = 0; i < 6; i++) begin
         strobe(bx[i], by[i]);
         flush();
      end

      wr_req = 1'b1;
      wr_addr = 6'd5;
      wr_data = 4'd3;
      for (int i = 0; i < 12; i++) strobe(8 + i * 3, 305);
      n = 0;
      while (!wr_ack && n < 50) begin
         cycle();
         n++;
      end
      chk("held_ack", 32'(wr_ack), 32'd1);
      wr_req = 1'b0;
      strobe(48, 300);
      flush();

      clr = 1'b1;
      cycle();
      clr = 1'b0;
      repeat (20) cycle();
      wr_req = 1'b1;
      wr_addr = 6'd7;
      wr_data = 4'd9;
      clr = 1'b1;
      cycle();
      clr = 1'b0;
      n = 0;
      while (busy && n < 200) begin
         cycle();
         n++;
      end
      chk("clr_restart", 32'(n), 32'd64);
      n = 0;
      while (!wr_ack && n < 10) begin
         cycle();
         n++;
      end
      chk("ack_after_clr", 32'(wr_ack), 32'd1);
      wr_req = 1'b0;
      strobe(64, 300);
      flush();

      n = 0;
      while (busy8 && n < 100) begin
         cycle();
         n++;
      end
      chk("busy8", 32'(busy8), 32'd0);
      write8(6'd31, 4'd5, "ack8_in");
      write8(6'd40, 4'd3, "ack8_oor");
      read8(8, 308, 4'd15, "char8_cell8");
      read8(64, 324, 4'd5, "char8_cell31");

      rand_run(3000);

      #3;
      do_reset();
      n = 0;
      while (busy && n < 200) begin
         cycle();
         n++;
      end
      chk("clr_len2", 32'(n), 32'd64);
      rand_run(500);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
